quad_enc_mc: RTL and testbench

Multi-channel quadrature decoder, the parametrised successor to the single-channel decoder. It provides NCH independent A/B/Z channels, each with a 2-flop synchroniser, a runtime-programmable glitch filter, signed position with a multiplier, and index (Z) capture with optional zeroing. Each channel also has a sticky fault with a saturating error counter and a step-period measurement for velocity estimation. It sits between the encoder input pins and the register/SPI layer, alongside the stepper and DC motor cores.

---
 rtl/quad_enc_pkg.sv | 18 +
 rtl/quad_enc_chan.sv | 189 ++++++++++++++++++
 rtl/quad_enc_mc.sv | 54 +++++
 tb/tb_quad_enc_mc.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_enc_pkg.sv
// Shared constants and types for the quadrature decoder channels.
package quad_enc_pkg;

    localparam int unsigned ERRBITS = 8;
    localparam logic [ERRBITS-1:0] ERR_MAX = '1;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Filtered {A,B} pin pair.
    typedef enum logic [1:0] {
        AB_00 = 2'b00,
        AB_01 = 2'b01,
        AB_10 = 2'b10,
        AB_11 = 2'b11
    } ab_t;

endpackage

// File: rtl/quad_enc_chan.sv
// One quadrature channel: synchroniser, A/B/Z glitch filters, step decode,
// index capture, fault tracking and step-period measurement.
module quad_enc_chan
    import quad_enc_pkg::*;
#(
    parameter int unsigned ENCBITS  = 32,
    parameter int unsigned FILTBITS = 4,
    parameter int unsigned VELBITS  = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                a_i,
    input  logic                b_i,
    input  logic                z_i,
    input  logic [7:0]          multiplier_i,
    input  logic [FILTBITS-1:0] filt_len_i,
    input  logic                index_zero_en_i,
    input  logic                fault_clr_i,
    output logic [ENCBITS-1:0]  count_o,
    output logic [ENCBITS-1:0]  index_count_o,
    output logic                index_valid_o,
    output logic                faultn_o,
    output logic [ERRBITS-1:0]  err_cnt_o,
    output logic [VELBITS-1:0]  period_o,
    output logic                dir_o
);

    localparam logic [VELBITS-1:0] PER_MAX = '1;

    // Bit order for the per-signal vectors: [2]=A, [1]=B, [0]=Z.
    logic [2:0]                s1_q;
    logic [2:0]                s2_q;
    logic [2:0]                filt_q,  filt_d;
    logic [2:0][FILTBITS-1:0]  run_q,   run_d;

    ab_t                       prev_ab_q, prev_ab_d;
    logic                      prev_z_q,  prev_z_d;

    logic [ENCBITS-1:0]        count_q,   count_d;
    logic [ENCBITS-1:0]        idx_q,     idx_d;
    logic                      valid_q,   valid_d;
    logic                      faultn_q,  faultn_d;
    logic [ERRBITS-1:0]        err_q,     err_d;
    logic [VELBITS-1:0]        period_q,  period_d;
    logic [VELBITS-1:0]        per_cnt_q, per_cnt_d;
    logic                      dir_q,     dir_d;

    logic [1:0]                ab_now;
    logic [1:0]                ab_prev;
    logic                      a_chg, b_chg;
    logic                      step, fault, up, z_rise;
    logic [ENCBITS-1:0]        mult_ext;
    logic [ENCBITS-1:0]        base;

    // Two-flop synchroniser for the asynchronous pins (intentionally unreset).
    always_ff @(posedge clk) begin
        s1_q <= {a_i, b_i, z_i};
        s2_q <= s1_q;
    end

    // Run-length glitch filters; in reset the filter output follows the pin directly.
    always_comb begin
        filt_d = filt_q;
        run_d  = run_q;
        for (int unsigned i = 0; i < 3; i++) begin
            if (!resetn) begin
                filt_d[i] = s2_q[i];
                run_d[i]  = '0;
            end else if (s2_q[i] == filt_q[i]) begin
                run_d[i]  = '0;
            end else if (run_q[i] >= filt_len_i) begin
                filt_d[i] = s2_q[i];
                run_d[i]  = '0;
            end else begin
                run_d[i]  = run_q[i] + FILTBITS'(1);
            end
        end
    end

    // Classify the filtered transition against the previous filtered state.
    always_comb begin
        ab_now   = filt_q[2:1];
        ab_prev  = prev_ab_q;
        a_chg    = ab_now[1] ^ ab_prev[1];
        b_chg    = ab_now[0] ^ ab_prev[0];
        step     = a_chg ^ b_chg;
        fault    = a_chg & b_chg;
        up       = ab_now[1] ^ ab_prev[0];
        z_rise   = filt_q[0] & ~prev_z_q;
        mult_ext = ENCBITS'(multiplier_i);
    end

    // Next-state for position, index, fault and period tracking.
    // In reset the previous-state registers load the value the filters are
    // loading, so the first cycle after release sees no edge.
    always_comb begin
        prev_ab_d = prev_ab_q;
        prev_z_d  = prev_z_q;
        count_d   = count_q;
        idx_d     = idx_q;
        valid_d   = 1'b0;
        faultn_d  = faultn_q;
        err_d     = err_q;
        period_d  = period_q;
        per_cnt_d = per_cnt_q;
        dir_d     = dir_q;
        base      = count_q;

        if (!resetn) begin
            prev_ab_d = ab_t'(s2_q[2:1]);
            prev_z_d  = s2_q[0];
            count_d   = '0;
            idx_d     = '0;
            faultn_d  = 1'b1;
            err_d     = '0;
            period_d  = PER_MAX;
            per_cnt_d = PER_MAX;
            dir_d     = DIR_UP;
        end else begin
            prev_ab_d = ab_t'(filt_q[2:1]);
            prev_z_d  = filt_q[0];

            // Index capture sees the position before this cycle's step.
            if (z_rise) begin
                idx_d   = count_q;
                valid_d = 1'b1;
                if (index_zero_en_i) begin
                    base = '0;
                end
            end

            if (step) begin
                count_d = up ? (base + mult_ext) : (base - mult_ext);
            end else begin
                count_d = base;
            end

            // Clear first so a coincident fault leaves a count of one.
            if (fault_clr_i) begin
                faultn_d = 1'b1;
                err_d    = '0;
            end
            if (fault) begin
                faultn_d = 1'b0;
                if (err_d != ERR_MAX) begin
                    err_d = err_d + ERRBITS'(1);
                end
            end

            if (step) begin
                period_d  = per_cnt_q;
                per_cnt_d = VELBITS'(1);
                dir_d     = up ? DIR_UP : DIR_DOWN;
            end else begin
                if (per_cnt_q != PER_MAX) begin
                    per_cnt_d = per_cnt_q + VELBITS'(1);
                end
                if (per_cnt_d == PER_MAX) begin
                    period_d = PER_MAX;
                end
            end
        end
    end

    // Channel state registers.
    always_ff @(posedge clk) begin
        filt_q    <= filt_d;
        run_q     <= run_d;
        prev_ab_q <= prev_ab_d;
        prev_z_q  <= prev_z_d;
        count_q   <= count_d;
        idx_q     <= idx_d;
        valid_q   <= valid_d;
        faultn_q  <= faultn_d;
        err_q     <= err_d;
        period_q  <= period_d;
        per_cnt_q <= per_cnt_d;
        dir_q     <= dir_d;
    end

    assign count_o       = count_q;
    assign index_count_o = idx_q;
    assign index_valid_o = valid_q;
    assign faultn_o      = faultn_q;
    assign err_cnt_o     = err_q;
    assign period_o      = period_q;
    assign dir_o         = dir_q;

endmodule

// File: rtl/quad_enc_mc.sv
// Multi-channel quadrature decoder: NCH independent channels packed into
// flat output buses, channel i at slice [i*WIDTH +: WIDTH].
module quad_enc_mc
    import quad_enc_pkg::*;
#(
    parameter int unsigned NCH      = 2,
    parameter int unsigned ENCBITS  = 32,
    parameter int unsigned FILTBITS = 4,
    parameter int unsigned VELBITS  = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NCH-1:0]           a,
    input  logic [NCH-1:0]           b,
    input  logic [NCH-1:0]           z,
    input  logic [7:0]               multiplier,
    input  logic [FILTBITS-1:0]      filt_len,
    input  logic [NCH-1:0]           index_zero_en,
    input  logic [NCH-1:0]           fault_clr,
    output logic [NCH*ENCBITS-1:0]   count,
    output logic [NCH*ENCBITS-1:0]   index_count,
    output logic [NCH-1:0]           index_valid,
    output logic [NCH-1:0]           faultn,
    output logic [NCH*ERRBITS-1:0]   err_cnt,
    output logic [NCH*VELBITS-1:0]   period,
    output logic [NCH-1:0]           dir
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        quad_enc_chan #(
            .ENCBITS  (ENCBITS),
            .FILTBITS (FILTBITS),
            .VELBITS  (VELBITS)
        ) u_chan (
            .clk             (clk),
            .resetn          (resetn),
            .a_i             (a[i]),
            .b_i             (b[i]),
            .z_i             (z[i]),
            .multiplier_i    (multiplier),
            .filt_len_i      (filt_len),
            .index_zero_en_i (index_zero_en[i]),
            .fault_clr_i     (fault_clr[i]),
            .count_o         (count[i*ENCBITS +: ENCBITS]),
            .index_count_o   (index_count[i*ENCBITS +: ENCBITS]),
            .index_valid_o   (index_valid[i]),
            .faultn_o        (faultn[i]),
            .err_cnt_o       (err_cnt[i*ERRBITS +: ERRBITS]),
            .period_o        (period[i*VELBITS +: VELBITS]),
            .dir_o           (dir[i])
        );
    end

endmodule

// File: tb/tb_quad_enc_mc.sv
// Self-checking bench for quad_enc_mc: table-driven counting, hand-written
// corner sequences, and randomized traffic against a position-level model.
module tb_quad_enc_mc;

    localparam int NCH  = 2;
    localparam int EB   = 8;
    localparam int FB   = 4;
    localparam int VB   = 10;
    localparam int PMAX = (1 << VB) - 1;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic [NCH-1:0]       a, b, z, index_zero_en, fault_clr;
    logic [7:0]           multiplier;
    logic [FB-1:0]        filt_len;
    logic [NCH*EB-1:0]    count, index_count;
    logic [NCH-1:0]       index_valid, faultn, dir;
    logic [NCH*8-1:0]     err_cnt;
    logic [NCH*VB-1:0]    period;

    always #5 clk = ~clk;

    quad_enc_mc #(
        .NCH      (NCH),
        .ENCBITS  (EB),
        .FILTBITS (FB),
        .VELBITS  (VB)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .a             (a),
        .b             (b),
        .z             (z),
        .multiplier    (multiplier),
        .filt_len      (filt_len),
        .index_zero_en (index_zero_en),
        .fault_clr     (fault_clr),
        .count         (count),
        .index_count   (index_count),
        .index_valid   (index_valid),
        .faultn        (faultn),
        .err_cnt       (err_cnt),
        .period        (period),
        .dir           (dir)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pos [NCH];

    typedef struct {
        logic       a0;
        logic       b0;
        logic [7:0] exp_cnt;
        logic       exp_dir;
    } vec_t;
    vec_t vt [11];

    // Reference model state (position-level, per channel).
    int m_cnt  [NCH];
    int m_idx  [NCH];
    int m_err  [NCH];
    int m_fn   [NCH];
    int m_dir  [NCH];
    int m_per  [NCH];
    int m_last [NCH];

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Quadrature position 0..3 in up order 00,10,11,01.
    function automatic logic [1:0] ab_of(input int p);
        case (p & 3)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic set_pos(input int ch, input int p);
        logic [1:0] v;
        v = ab_of(p);
        pos[ch] = p & 3;
        a[ch] = v[1];
        b[ch] = v[0];
    endtask

    function automatic logic [31:0] f_cnt(input int ch);   return 32'(count[ch*EB +: EB]);       endfunction
    function automatic logic [31:0] f_idx(input int ch);   return 32'(index_count[ch*EB +: EB]); endfunction
    function automatic logic [31:0] f_err(input int ch);   return 32'(err_cnt[ch*8 +: 8]);       endfunction
    function automatic logic [31:0] f_per(input int ch);   return 32'(period[ch*VB +: VB]);      endfunction

    task automatic check_reset_state(input string tag);
        for (int ch = 0; ch < NCH; ch++) begin
            chk($sformatf("%s_count%0d", tag, ch), f_cnt(ch), 0);
            chk($sformatf("%s_idx%0d", tag, ch), f_idx(ch), 0);
            chk($sformatf("%s_valid%0d", tag, ch), 32'(index_valid[ch]), 0);
            chk($sformatf("%s_faultn%0d", tag, ch), 32'(faultn[ch]), 1);
            chk($sformatf("%s_err%0d", tag, ch), f_err(ch), 0);
            chk($sformatf("%s_period%0d", tag, ch), f_per(ch), PMAX);
            chk($sformatf("%s_dir%0d", tag, ch), 32'(dir[ch]), 1);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < NCH; ch++) begin
            m_cnt[ch] = 0; m_idx[ch] = 0; m_err[ch] = 0; m_fn[ch] = 1;
            m_dir[ch] = 1; m_per[ch] = PMAX; m_last[ch] = -1;
        end
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Up 8 edges from 00, then 3 down edges.
        vt[0]  = '{1'b1, 1'b0, 8'd1, 1'b1};
        vt[1]  = '{1'b1, 1'b1, 8'd2, 1'b1};
        vt[2]  = '{1'b0, 1'b1, 8'd3, 1'b1};
        vt[3]  = '{1'b0, 1'b0, 8'd4, 1'b1};
        vt[4]  = '{1'b1, 1'b0, 8'd5, 1'b1};
        vt[5]  = '{1'b1, 1'b1, 8'd6, 1'b1};
        vt[6]  = '{1'b0, 1'b1, 8'd7, 1'b1};
        vt[7]  = '{1'b0, 1'b0, 8'd8, 1'b1};
        vt[8]  = '{1'b0, 1'b1, 8'd7, 1'b0};
        vt[9]  = '{1'b1, 1'b1, 8'd6, 1'b0};
        vt[10] = '{1'b1, 1'b0, 8'd5, 1'b0};

        a = '0; b = '0; z = '0;
        index_zero_en = '0; fault_clr = '0;
        multiplier = 8'd1; filt_len = '0;
        pos[0] = 0; pos[1] = 0;
        resetn = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        tick();
        check_reset_state("rst0");

        // Table-driven up/down counting on channel 0.
        for (int i = 0; i < 11; i++) begin
            a[0] = vt[i].a0;
            b[0] = vt[i].b0;
            repeat (4) tick();
            chk($sformatf("tbl_count_%0d", i), f_cnt(0), 32'(vt[i].exp_cnt));
            chk($sformatf("tbl_dir_%0d", i), 32'(dir[0]), 32'(vt[i].exp_dir));
            chk($sformatf("tbl_ch1_%0d", i), f_cnt(1), 0);
        end
        pos[0] = 1;

        // Glitch filter with filt_len=3.
        set_pos(0, 0);
        repeat (4) tick();
        chk("glitch_pre", f_cnt(0), 4);
        filt_len = 4'd3;
        a[0] = 1'b1;
        repeat (3) tick();
        a[0] = 1'b0;
        repeat (10) tick();
        chk("glitch_short", f_cnt(0), 4);
        set_pos(0, 1);
        repeat (6) tick();
        chk("glitch_edge5", f_cnt(0), 4);
        tick();
        chk("glitch_edge6", f_cnt(0), 5);
        filt_len = '0;
        repeat (2) tick();

        // Faults: both pins toggle together.
        set_pos(0, pos[0] + 2);
        repeat (4) tick();
        chk("fault_n", 32'(faultn[0]), 0);
        chk("fault_err1", f_err(0), 1);
        chk("fault_count", f_cnt(0), 5);
        for (int i = 0; i < 299; i++) begin
            set_pos(0, pos[0] + 2);
            repeat (2) tick();
        end
        repeat (4) tick();
        chk("fault_sat", f_err(0), 255);
        chk("fault_sat_n", 32'(faultn[0]), 0);
        chk("fault_sat_count", f_cnt(0), 5);
        fault_clr[0] = 1'b1;
        tick();
        fault_clr[0] = 1'b0;
        tick();
        chk("clr_n", 32'(faultn[0]), 1);
        chk("clr_err", f_err(0), 0);
        set_pos(0, pos[0] + 2);
        repeat (4) tick();
        set_pos(0, pos[0] + 2);
        repeat (3) tick();
        fault_clr[0] = 1'b1;
        tick();
        fault_clr[0] = 1'b0;
        tick();
        chk("clr_coinc_n", 32'(faultn[0]), 0);
        chk("clr_coinc_err", f_err(0), 1);
        fault_clr[0] = 1'b1;
        tick();
        fault_clr[0] = 1'b0;
        tick();

        // Index capture and zeroing.
        multiplier = 8'd95;
        set_pos(0, pos[0] + 1);
        repeat (4) tick();
        chk("idx_setup", f_cnt(0), 100);
        index_zero_en[0] = 1'b1;
        z[0] = 1'b1;
        repeat (3) tick();
        chk("idx_valid_pre", 32'(index_valid[0]), 0);
        tick();
        chk("idx_valid", 32'(index_valid[0]), 1);
        chk("idx_capture", f_idx(0), 100);
        chk("idx_zeroed", f_cnt(0), 0);
        tick();
        chk("idx_valid_post", 32'(index_valid[0]), 0);
        z[0] = 1'b0;
        repeat (4) tick();
        multiplier = 8'd4;
        repeat (2) begin
            set_pos(0, pos[0] + 1);
            repeat (4) tick();
        end
        chk("idx2_setup", f_cnt(0), 8);
        z[0] = 1'b1;
        set_pos(0, pos[0] + 1);
        repeat (4) tick();
        chk("idx2_count", f_cnt(0), 4);
        chk("idx2_capture", f_idx(0), 8);
        z[0] = 1'b0;
        index_zero_en[0] = 1'b0;
        repeat (4) tick();

        // Wrap and period.
        multiplier = 8'd123;
        set_pos(0, pos[0] + 1);
        repeat (4) tick();
        chk("wrap_127", f_cnt(0), 127);
        multiplier = 8'd1;
        set_pos(0, pos[0] + 1);
        repeat (4) tick();
        chk("wrap_m128", f_cnt(0), 32'h80);
        set_pos(0, pos[0] + 1);
        repeat (10) tick();
        set_pos(0, pos[0] + 1);
        repeat (4) tick();
        chk("period_10", f_per(0), 10);
        for (int i = 0; i < 3; i++) begin
            set_pos(0, pos[0] + 1);
            tick();
        end
        repeat (3) tick();
        chk("period_1", f_per(0), 1);
        chk("period_1_dir", 32'(dir[0]), 1);
        repeat (PMAX + 20) tick();
        chk("period_stall", f_per(0), PMAX);

        // Reset while a filter run is in progress.
        filt_len = 4'd3;
        a = '1; b = '1;
        pos[0] = 2; pos[1] = 2;
        repeat (3) tick();
        resetn = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        tick();
        check_reset_state("rst1");
        repeat (8) tick();
        check_reset_state("rst1_late");

        // Randomized traffic against the position-level model.
        for (int bt = 0; bt < 8; bt++) begin
            int fl;
            int mul;
            fl = $urandom_range(0, 3);
            mul = $urandom_range(1, 255);
            filt_len = FB'(fl);
            multiplier = 8'(mul);
            index_zero_en = NCH'($urandom);
            resetn = 1'b0;
            repeat (3) tick();
            resetn = 1'b1;
            tick();
            model_reset();
            for (int sg = 0; sg < 30; sg++) begin
                int h;
                int t0;
                int gl_len [NCH];
                int gl_pin [NCH];
                logic zr [NCH];
                h = fl + 4 + $urandom_range(0, 4);
                t0 = cyc;
                for (int ch = 0; ch < NCH; ch++) begin
                    int act;
                    int np;
                    int d;
                    act = $urandom_range(0, 9);
                    gl_len[ch] = 0;
                    gl_pin[ch] = 0;
                    zr[ch] = 1'b0;
                    np = pos[ch];
                    if (act <= 2 || act == 8) np = pos[ch] + 1;
                    else if (act <= 4) np = pos[ch] + 3;
                    else if (act == 5) np = pos[ch] + 2;
                    if (act == 7 || act == 8) begin
                        z[ch] = ~z[ch];
                        zr[ch] = z[ch];
                    end
                    if (act == 6 && fl > 0) begin
                        gl_len[ch] = $urandom_range(1, fl);
                        gl_pin[ch] = $urandom_range(0, 1);
                        if (gl_pin[ch] == 0) a[ch] = ~a[ch];
                        else b[ch] = ~b[ch];
                    end
                    d = ((np & 3) - pos[ch] + 4) % 4;
                    if (np != pos[ch]) set_pos(ch, np);
                    if (zr[ch]) begin
                        m_idx[ch] = m_cnt[ch];
                        if (index_zero_en[ch]) m_cnt[ch] = 0;
                    end
                    if (d == 1 || d == 3) begin
                        m_cnt[ch] = (d == 1) ? m_cnt[ch] + mul : m_cnt[ch] - mul;
                        m_cnt[ch] = m_cnt[ch] & 8'hFF;
                        m_per[ch] = (m_last[ch] < 0 || t0 - m_last[ch] > PMAX) ? PMAX : t0 - m_last[ch];
                        m_last[ch] = t0;
                        m_dir[ch] = (d == 1) ? 1 : 0;
                    end else if (d == 2) begin
                        m_fn[ch] = 0;
                        if (m_err[ch] < 255) m_err[ch]++;
                    end
                end
                for (int k = 0; k < h; k++) begin
                    for (int ch = 0; ch < NCH; ch++) begin
                        if (gl_len[ch] != 0 && k == gl_len[ch]) begin
                            if (gl_pin[ch] == 0) a[ch] = ~a[ch];
                            else b[ch] = ~b[ch];
                        end
                    end
                    tick();
                end
                for (int ch = 0; ch < NCH; ch++) begin
                    chk($sformatf("rnd_count%0d", ch), f_cnt(ch), 32'(m_cnt[ch]));
                    chk($sformatf("rnd_idx%0d", ch), f_idx(ch), 32'(m_idx[ch] & 8'hFF));
                    chk($sformatf("rnd_err%0d", ch), f_err(ch), 32'(m_err[ch]));
                    chk($sformatf("rnd_faultn%0d", ch), 32'(faultn[ch]), 32'(m_fn[ch]));
                    chk($sformatf("rnd_dir%0d", ch), 32'(dir[ch]), 32'(m_dir[ch]));
                    chk($sformatf("rnd_period%0d", ch), f_per(ch), 32'(m_per[ch]));
                    chk($sformatf("rnd_valid%0d", ch), 32'(index_valid[ch]),
                        32'(zr[ch] && (h == fl + 4)));
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
